// File: rtl/button_event_decoder_if.sv
// Event delivery handshake between the button decoder and its consumer.
// The producer drives valid/code, and the consumer answers with ready.
interface button_event_decoder_if;
    logic       event_valid;
    logic [1:0] event_code;
    logic       event_ready;

    modport master (
        output event_valid,
        output event_code,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_code,
        output event_ready
    );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into SHORT/DOUBLE/LONG/REPEAT events.
// Optional auto-repeat while held: define BUTTON_EVENT_AUTOREPEAT_EN.
module button_event_decoder #(
    parameter int G_LONG_PRESS_CYCLES    = 25_000_000,
    parameter int G_DOUBLE_GAP_CYCLES    = 12_500_000,
    parameter int G_REPEAT_PERIOD_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic din_debounced,
    output logic pressed,
    output logic event_overflow,
    button_event_decoder_if.master ev
);

    localparam int MAX_AB = (G_LONG_PRESS_CYCLES > G_DOUBLE_GAP_CYCLES) ?
                            G_LONG_PRESS_CYCLES : G_DOUBLE_GAP_CYCLES;
    localparam int MAXP = (MAX_AB > G_REPEAT_PERIOD_CYCLES) ?
                          MAX_AB : G_REPEAT_PERIOD_CYCLES;
    localparam int CW = $clog2(MAXP + 1);

    // The entry sample counts as sample 1, so the last compare is N-2.
    localparam logic [CW-1:0] LONG_LAST = CW'(G_LONG_PRESS_CYCLES - 2);
    localparam logic [CW-1:0] GAP_LAST  = CW'(G_DOUBLE_GAP_CYCLES - 2);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(G_REPEAT_PERIOD_CYCLES - 1);
`endif

    localparam logic [1:0] EV_SHORT  = 2'd0;
    localparam logic [1:0] EV_DOUBLE = 2'd1;
    localparam logic [1:0] EV_LONG   = 2'd2;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
    localparam logic [1:0] EV_REPEAT = 2'd3;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT_GAP,
        S_PRESS2,
        S_LONG_HELD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          din_q;
    logic          valid_q, valid_d;
    logic [1:0]    code_q, code_d;
    logic          ovf_q, ovf_d;

    logic          rise, fall;
    logic          new_ev;
    logic [1:0]    new_code;

    assign rise = din_debounced & ~din_q;
    assign fall = ~din_debounced & din_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        new_ev   = 1'b0;
        new_code = EV_SHORT;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESS1;
                    cnt_d   = '0;
                end
            end
            S_PRESS1: begin
                if (fall) begin
                    state_d = S_WAIT_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    new_ev   = 1'b1;
                    new_code = EV_LONG;
                    state_d  = S_LONG_HELD;
                    cnt_d    = '0;
                end
            end
            S_WAIT_GAP: begin
                if (rise) begin
                    state_d = S_PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    new_ev   = 1'b1;
                    new_code = EV_SHORT;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end
            end
            S_PRESS2: begin
                if (fall) begin
                    new_ev   = 1'b1;
                    new_code = EV_DOUBLE;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end
            end
            S_LONG_HELD: begin
                if (fall) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
                end else if (cnt_q == REP_LAST) begin
                    new_ev   = 1'b1;
                    new_code = EV_REPEAT;
                    cnt_d    = '0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Single-entry event slot: a new event never overwrites an unaccepted one.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovf_d   = ovf_q;
        if (new_ev) begin
            if (!valid_q || ev.event_ready) begin
                valid_d = 1'b1;
                code_d  = new_code;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && ev.event_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            din_q   <= 1'b0;
            valid_q <= 1'b0;
            code_q  <= EV_SHORT;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_debounced;
            valid_q <= valid_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pressed        = din_q;
    assign event_overflow = ovf_q;
    assign ev.event_valid = valid_q;
    assign ev.event_code  = code_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder (LONG=20, GAP=10, REPEAT=8).
// Segments of constant din/ready carry the hand-placed event sample.
module tb_button_event_decoder;

    localparam logic [1:0] C_SHORT  = 2'd0;
    localparam logic [1:0] C_DOUBLE = 2'd1;
    localparam logic [1:0] C_LONG   = 2'd2;
    localparam logic [1:0] C_REPEAT = 2'd3;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
    localparam int REP_AT = 8;
`else
    localparam int REP_AT = 0;
`endif

    typedef struct {
        bit         din;
        bit         rdy;
        int         n;
        int         at;
        logic [1:0] code;
    } seg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic pressed;
    logic ovf;

    button_event_decoder_if bus();

    button_event_decoder #(
        .G_LONG_PRESS_CYCLES   (20),
        .G_DOUBLE_GAP_CYCLES   (10),
        .G_REPEAT_PERIOD_CYCLES(8)
    ) dut (
        .clk           (clk),
        .reset         (rst),
        .din_debounced (din),
        .pressed       (pressed),
        .event_overflow(ovf),
        .ev            (bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit         mv;
    logic [1:0] mc;
    bit         movf;

    seg_t tbl[$];
    int   split;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic step(input string nm, input bit d, input bit r,
                        input bit ev, input logic [1:0] code);
        din = d;
        bus.event_ready = r;
        @(posedge clk);
        #1;
        if (ev) begin
            if (!mv || r) begin
                mv = 1'b1;
                mc = code;
            end else begin
                movf = 1'b1;
            end
        end else if (mv && r) begin
            mv = 1'b0;
        end
        chk({nm, ".valid"}, 32'(bus.event_valid), 32'(mv));
        if (mv) chk({nm, ".code"}, 32'(bus.event_code), 32'(mc));
        chk({nm, ".ovf"}, 32'(ovf), 32'(movf));
        chk({nm, ".pressed"}, 32'(pressed), 32'(d));
    endtask

    task automatic do_reset(input bit d, input int n);
        rst = 1'b1;
        din = d;
        bus.event_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst.valid", 32'(bus.event_valid), 0);
            chk("rst.code", 32'(bus.event_code), 0);
            chk("rst.ovf", 32'(ovf), 0);
            chk("rst.pressed", 32'(pressed), 0);
        end
        mv   = 1'b0;
        mc   = C_SHORT;
        movf = 1'b0;
        rst  = 1'b0;
    endtask

    task automatic run_tbl(input int lo, input int hi);
        for (int s = lo; s < hi; s++) begin
            for (int j = 1; j <= tbl[s].n; j++) begin
                step($sformatf("seg%0d.c%0d", s, j), tbl[s].din,
                     tbl[s].rdy, (j == tbl[s].at), tbl[s].code);
            end
        end
    endtask

    function automatic seg_t mk(bit d, bit r, int n, int at, logic [1:0] c);
        seg_t s;
        s.din  = d;
        s.rdy  = r;
        s.n    = n;
        s.at   = at;
        s.code = c;
        return s;
    endfunction

    initial begin
        bus.event_ready = 1'b1;
        // single short press
        tbl.push_back(mk(1, 1, 5, 0, C_SHORT));
        tbl.push_back(mk(0, 1, 15, 10, C_SHORT));
        // double press
        tbl.push_back(mk(1, 1, 5, 0, C_SHORT));
        tbl.push_back(mk(0, 1, 3, 0, C_SHORT));
        tbl.push_back(mk(1, 1, 5, 0, C_SHORT));
        tbl.push_back(mk(0, 1, 12, 1, C_DOUBLE));
        // long hold of 50 samples, then release
        tbl.push_back(mk(1, 1, 20, 20, C_LONG));
        tbl.push_back(mk(1, 1, 8, REP_AT, C_REPEAT));
        tbl.push_back(mk(1, 1, 8, REP_AT, C_REPEAT));
        tbl.push_back(mk(1, 1, 8, REP_AT, C_REPEAT));
        tbl.push_back(mk(1, 1, 6, 0, C_SHORT));
        tbl.push_back(mk(0, 1, 5, 0, C_SHORT));
        // consumer stalled: SHORT held, LONG dropped
        tbl.push_back(mk(1, 0, 5, 0, C_SHORT));
        tbl.push_back(mk(0, 0, 10, 10, C_SHORT));
        tbl.push_back(mk(1, 0, 20, 20, C_LONG));
        tbl.push_back(mk(1, 0, 4, 0, C_SHORT));
        tbl.push_back(mk(0, 0, 3, 0, C_SHORT));
        tbl.push_back(mk(0, 1, 2, 0, C_SHORT));
        split = tbl.size();
        // DOUBLE arrives in the same cycle the pending SHORT is accepted
        tbl.push_back(mk(1, 0, 5, 0, C_SHORT));
        tbl.push_back(mk(0, 0, 10, 10, C_SHORT));
        tbl.push_back(mk(0, 0, 2, 0, C_SHORT));
        tbl.push_back(mk(1, 0, 3, 0, C_SHORT));
        tbl.push_back(mk(0, 0, 2, 0, C_SHORT));
        tbl.push_back(mk(1, 0, 3, 0, C_SHORT));
        tbl.push_back(mk(0, 1, 3, 1, C_DOUBLE));
        tbl.push_back(mk(0, 1, 12, 0, C_SHORT));

        do_reset(1'b0, 2);
        run_tbl(0, split);

        // reset on the 10th high sample abandons the press silently
        for (int i = 1; i <= 9; i++)
            step($sformatf("mid.c%0d", i), 1, 1, 0, C_SHORT);
        do_reset(1'b1, 2);
        for (int i = 1; i <= 20; i++)
            step($sformatf("post.c%0d", i), 1, 1, (i == 20), C_LONG);
        step("post.rel1", 0, 1, 0, C_SHORT);
        step("post.rel2", 0, 1, 0, C_SHORT);

        run_tbl(split, tbl.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies a debounced push-button level into discrete user events: short press, double press, long press and (optionally) auto-repeat while held. Sits directly downstream of the input debouncer, taking its clean `dout_debounced` level and delivering one-hot-free 2-bit event codes over a valid/ready handshake to control logic such as register-bank menus or mode selectors.

## Interface
- `G_LONG_PRESS_CYCLES`, 25_000_000: consecutive high samples that qualify a long press (≥2)
- `G_DOUBLE_GAP_CYCLES`, 12_500_000: max low samples between releases and second press for a double press (≥2)
- `G_REPEAT_PERIOD_CYCLES`, 5_000_000: cycles between repeat events after long press (≥2; used only with auto-repeat)

- `clk` in 1: system clock, all logic on rising edge
- `reset` in 1: synchronous, active-high reset
- `din_debounced` in 1: debounced button level, 1 = pressed
- `pressed` out 1: registered copy of `din_debounced`
- `event_valid` out 1: event register holds an undelivered event
- `event_code` out 2: 0 SHORT, 1 DOUBLE, 2 LONG, 3 REPEAT
- `event_ready` in 1: consumer accepts event when high with `event_valid`
- `event_overflow` out 1: sticky; an event was dropped

## Operation
- Edge detect: `din_q` register; rise = din & ~din_q, fall = ~din & din_q.
- Single counter `cnt`, width $clog2(max parameter + 1), cleared on every state entry, saturating (never wraps).
- FSM states:
  - IDLE: rise → PRESS1.
  - PRESS1: din high on G_LONG_PRESS_CYCLES consecutive samples (counting the rise sample as 1) → emit LONG, → LONG_HELD. Fall earlier → WAIT_GAP.
  - WAIT_GAP: rise while fewer than G_DOUBLE_GAP_CYCLES low samples seen → PRESS2. G_DOUBLE_GAP_CYCLES-th consecutive low sample (fall sample = 1) → emit SHORT, → IDLE.
  - PRESS2: fall → emit DOUBLE, → IDLE. No LONG from PRESS2 regardless of hold length.
  - LONG_HELD: fall → IDLE (no event). Auto-repeat per Configuration.
- Event register: one entry. New event loads when `event_valid`=0 or (`event_valid`&&`event_ready`) same cycle. New event while `event_valid`&&!`event_ready` → discarded, `event_overflow` set; held event unchanged.
- Accept without new event clears `event_valid`. `event_code` stable while `event_valid`=1 and not accepted.
- `event_overflow` clears only on `reset`.

## Timing
- Reset values: state IDLE, `cnt`=0, `din_q`=0, `pressed`=0, `event_valid`=0, `event_code`=0, `event_overflow`=0.
- Input held high across reset release appears as a rise on the first post-reset sample → normal press.
- Event latency: `event_valid` high in the cycle following the clock edge sampling the qualifying condition (1 cycle).
- `pressed` lags `din_debounced` by 1 cycle.
- Reset mid-sequence abandons any partial press; no event emitted; dropped state not reported as overflow.
- Simultaneous accept and new event: new event visible next cycle, `event_valid` stays 1, no overflow.

## Configuration
- `BUTTON_EVENT_AUTOREPEAT_EN` defined: in LONG_HELD, emit REPEAT every G_REPEAT_PERIOD_CYCLES high samples after the LONG sample (first at LONG+G_REPEAT_PERIOD_CYCLES), counter restarts after each repeat; subject to same overflow rule.
- Undefined: LONG_HELD emits nothing; code 3 never produced; repeat counter logic absent.

## Test plan
(G_LONG=20, G_GAP=10, G_REPEAT=8, `event_ready`=1 unless noted)
- High 5 cycles, low 15 → exactly one SHORT, `event_valid` 1 cycle at 10th low sample + 1; no other events.
- High 5, low 3, high 5, low → one DOUBLE one cycle after fall sample; no SHORT.
- High 50 cycles → LONG at 20th high sample +1; with macro REPEAT at samples 28, 36, 44 (+1); without macro nothing further; release → no event.
- `event_ready`=0, SHORT then LONG sequence → `event_code`=0 held, LONG dropped, `event_overflow`=1; raise ready → SHORT accepted, `event_valid`=0, overflow stays 1.
- Reset asserted at 10th high sample of PRESS1, din kept high → all outputs 0 during reset; after release new press counted from first sample, LONG after 20 more high samples.
- Accept and new event same cycle (ready=1 as DOUBLE arrives while SHORT pending from prior window) → back-to-back valid cycles, correct codes, overflow 0.
